// File: rtl/pci_tgt_pkg.sv
// pci_tgt_pkg: shared state encoding, bus command codes and beat size for the PCI target sequencer.
package pci_tgt_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, XFER, TERM, ABORT} state_t;
  localparam logic [15:0] CMD_MEM_RD = 16'h0040;
  localparam logic [15:0] CMD_MEM_WR = 16'h0080;
  localparam int BEAT_BYTES = 4;
  function automatic logic cmd_ok(input logic [15:0] cmd, input logic wrdn);
    return wrdn ? (cmd == CMD_MEM_WR) : (cmd == CMD_MEM_RD);
  endfunction
endpackage

// File: rtl/pci_tgt_bar_prio.sv
// pci_tgt_bar_prio: priority encoder turning BAR hit strobes into a one-hot select and index; lowest index wins.
module pci_tgt_bar_prio #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  hit_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  assign any_o = |hit_i;
  assign onehot_o = hit_i & (~hit_i + 1'b1);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (hit_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl: PCI target user-side sequencer sharing the adio datapath between NUM_BAR backends.
// Optional beat/abort statistics outputs are enabled by defining PCI_TARGET_CTRL_STATS_EN.
module pci_target_ctrl
  import pci_tgt_pkg::*;
#(
  parameter int NUM_BAR     = 2,
  parameter int WAIT_STATES = 0,
  parameter int MAX_BURST   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_I,
  input  logic [7:0]           base_hit,
  input  logic                 s_wrdn,
  input  logic [15:0]          pci_cmd,
  input  logic [31:0]          addr,
  input  logic                 s_data,
  input  logic                 s_data_vld,
  input  logic [31:0]          adio_out,
  output logic [31:0]          adio_in,
  output logic                 s_ready,
  output logic                 s_term,
  output logic                 s_abort,
  output logic [NUM_BAR-1:0]   bk_sel,
  output logic [31:0]          bk_addr,
  output logic                 bk_wr,
  output logic [31:0]          bk_wdata,
  output logic                 bk_rd,
  input  logic [32*NUM_BAR-1:0] bk_rdata
`ifdef PCI_TARGET_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_beats,
  output logic [7:0]           stat_aborts
`endif
);
  localparam int IW = NUM_BAR > 1 ? $clog2(NUM_BAR) : 1;
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  state_t state_q;
  logic [NUM_BAR-1:0] hit_oh, sel_q;
  logic [IW-1:0] hit_idx, idx_q;
  logic hit_any, legal, active, beat, last, unused;
  logic wr_q, sdata_q, s_ready_q, s_term_q, s_abort_q, bk_wr_q;
  logic [31:0] addr_q, bk_addr_q, bk_wdata_q;
  logic [CW-1:0] beat_q;
  logic [3:0] wcnt_q;
  pci_tgt_bar_prio #(.N(NUM_BAR)) u_prio (
    .hit_i(base_hit[NUM_BAR-1:0]), .onehot_o(hit_oh), .idx_o(hit_idx), .any_o(hit_any)
  );
  assign unused = ^{base_hit, addr[1:0]};
  assign legal = cmd_ok(pci_cmd, s_wrdn);
  assign active = state_q inside {XFER, TERM};
  assign beat = active & s_data_vld;
  assign last = beat & (beat_q == CW'(MAX_BURST - 1));
  always_ff @(posedge CLK or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      sel_q <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      sdata_q <= 1'b0;
      s_ready_q <= 1'b0;
      s_term_q <= 1'b0;
      s_abort_q <= 1'b0;
      bk_wr_q <= 1'b0;
      addr_q <= '0;
      bk_addr_q <= '0;
      bk_wdata_q <= '0;
      beat_q <= '0;
      wcnt_q <= '0;
    end else begin
      sdata_q <= s_data;
      bk_wr_q <= beat & wr_q;
      // writes present the address of the beat being strobed; reads look ahead to the next beat
      if (beat) begin
        addr_q <= addr_q + 32'(BEAT_BYTES);
        bk_addr_q <= wr_q ? addr_q : addr_q + 32'(BEAT_BYTES);
        beat_q <= beat_q + 1'b1;
        if (wr_q) bk_wdata_q <= adio_out;
      end
      case (state_q)
        IDLE: if (hit_any) begin
          sel_q <= hit_oh;
          idx_q <= hit_idx;
          wr_q <= s_wrdn;
          addr_q <= {addr[31:2], 2'b00};
          bk_addr_q <= {addr[31:2], 2'b00};
          beat_q <= '0;
          if (!legal) begin
            state_q <= ABORT;
            s_abort_q <= 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_q <= XFER;
            s_ready_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            wcnt_q <= 4'(WAIT_STATES - 1);
          end
        end
        WAIT: if (wcnt_q == '0) begin
          state_q <= XFER;
          s_ready_q <= 1'b1;
        end else wcnt_q <= wcnt_q - 1'b1;
        XFER: if (sdata_q & ~s_data) begin
          state_q <= IDLE;
          s_ready_q <= 1'b0;
        end else if (last) begin
          state_q <= TERM;
          s_term_q <= 1'b1;
        end
        TERM: if (!s_data) begin
          state_q <= IDLE;
          s_ready_q <= 1'b0;
          s_term_q <= 1'b0;
        end
        ABORT: if (!s_data) begin
          state_q <= IDLE;
          s_abort_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign s_ready = s_ready_q;
  assign s_term = s_term_q;
  assign s_abort = s_abort_q;
  assign bk_sel = active ? sel_q : '0;
  assign bk_addr = bk_addr_q;
  assign bk_wr = bk_wr_q;
  assign bk_wdata = bk_wdata_q;
  assign bk_rd = beat & ~wr_q;
  assign adio_in = (active & ~wr_q & s_data) ? bk_rdata[32*idx_q +: 32] : '0;
`ifdef PCI_TARGET_CTRL_STATS_EN
  logic [15:0] stat_beats_q;
  logic [7:0] stat_aborts_q;
  always_ff @(posedge CLK or negedge RST_I) begin
    if (!RST_I) begin
      stat_beats_q <= '0;
      stat_aborts_q <= '0;
    end else begin
      if (beat && stat_beats_q != '1) stat_beats_q <= stat_beats_q + 1'b1;
      if (state_q == IDLE && hit_any && !legal && stat_aborts_q != '1) stat_aborts_q <= stat_aborts_q + 1'b1;
    end
  end
  assign stat_beats = stat_beats_q;
  assign stat_aborts = stat_aborts_q;
`endif
endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb_pci_target_ctrl: two DUT instances (WAIT_STATES=0/MAX_BURST=16 and WAIT_STATES=3/MAX_BURST=4)
// driven by a directed vector table, a reset sequence and randomized transactions checked per cycle.
module tb_pci_target_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] bh [2];
  logic wrdn [2];
  logic [15:0] cmd [2];
  logic [31:0] ad [2];
  logic sd [2];
  logic vl [2];
  logic [31:0] wdat [2];
  logic [63:0] rdat [2];
  logic [31:0] adio [2];
  logic rdy [2];
  logic trm [2];
  logic abt [2];
  logic [1:0] sel [2];
  logic [31:0] baddr [2];
  logic [31:0] bwd [2];
  logic bwr [2];
  logic brd [2];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pci_target_ctrl #(.NUM_BAR(2), .WAIT_STATES(0), .MAX_BURST(16)) dut0 (
    .CLK(clk), .RST_I(rst_n), .base_hit(bh[0]), .s_wrdn(wrdn[0]), .pci_cmd(cmd[0]), .addr(ad[0]),
    .s_data(sd[0]), .s_data_vld(vl[0]), .adio_out(wdat[0]), .adio_in(adio[0]), .s_ready(rdy[0]),
    .s_term(trm[0]), .s_abort(abt[0]), .bk_sel(sel[0]), .bk_addr(baddr[0]), .bk_wr(bwr[0]),
    .bk_wdata(bwd[0]), .bk_rd(brd[0]), .bk_rdata(rdat[0])
  );
  pci_target_ctrl #(.NUM_BAR(2), .WAIT_STATES(3), .MAX_BURST(4)) dut1 (
    .CLK(clk), .RST_I(rst_n), .base_hit(bh[1]), .s_wrdn(wrdn[1]), .pci_cmd(cmd[1]), .addr(ad[1]),
    .s_data(sd[1]), .s_data_vld(vl[1]), .adio_out(wdat[1]), .adio_in(adio[1]), .s_ready(rdy[1]),
    .s_term(trm[1]), .s_abort(abt[1]), .bk_sel(sel[1]), .bk_addr(baddr[1]), .bk_wr(bwr[1]),
    .bk_wdata(bwd[1]), .bk_rd(brd[1]), .bk_rdata(rdat[1])
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One transaction; expectations come from the latency, beat count and burst limit of unit u.
  task automatic run_txn(input int u, input logic [7:0] hit, input logic wr, input logic [15:0] c,
                         input logic [31:0] a, input int n, input logic [1:0] xsel, input logic xab,
                         input int lat);
    int done, e, na, mb;
    logic pv, rx, bar, fin;
    logic [31:0] st, pd, pa, xr;
    mb = u != 0 ? 4 : 16;
    st = a & 32'hFFFFFFFC;
    bar = xsel[1];
    done = 0; e = -1; pv = 1'b0; pd = '0; pa = '0; fin = 1'b0;
    @(posedge clk); #1;
    bh[u] = hit; wrdn[u] = wr; cmd[u] = c; ad[u] = a; sd[u] = 1'b0; vl[u] = 1'b0;
    @(negedge clk);
    chk1("hit_cycle_ready", rdy[u], 1'b0);
    chk1("hit_cycle_abort", abt[u], 1'b0);
    if (xsel == 2'b00) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        bh[u] = 8'h00;
        @(negedge clk);
        chk1("ignored_ready", rdy[u], 1'b0);
        chk1("ignored_abort", abt[u], 1'b0);
        chk32("ignored_sel", 32'(sel[u]), 32'h0);
      end
    end else if (xab) begin
      na = 1 + int'($urandom_range(0, 2));
      for (int i = 1; i <= na + 2; i++) begin
        @(posedge clk); #1;
        sd[u] = (i <= na); vl[u] = 1'b0;
        bh[u] = sd[u] ? 8'($urandom) : 8'h00;
        @(negedge clk);
        chk1("abort_flag", abt[u], i <= na + 1);
        chk1("abort_ready", rdy[u], 1'b0);
        chk1("abort_wr", bwr[u], 1'b0);
        chk1("abort_rd", brd[u], 1'b0);
        chk32("abort_sel", 32'(sel[u]), 32'h0);
      end
    end else begin
      for (int k = 1; k < 300; k++) begin
        @(posedge clk); #1;
        if (done < n) begin
          sd[u] = 1'b1;
          vl[u] = (k >= lat) && ($urandom_range(0, 3) != 0);
        end else begin
          if (e < 0) e = k;
          sd[u] = 1'b0; vl[u] = 1'b0;
        end
        bh[u] = sd[u] ? 8'($urandom) : 8'h00;
        wdat[u] = $urandom;
        rdat[u] = {$urandom, $urandom};
        @(negedge clk);
        rx = (k >= lat) && (e < 0 || k <= e);
        xr = bar ? rdat[u][63:32] : rdat[u][31:0];
        chk1("ready", rdy[u], rx);
        chk1("term", trm[u], rx && done >= mb);
        chk1("abort_idle", abt[u], 1'b0);
        chk32("sel", 32'(sel[u]), rx ? 32'(xsel) : 32'h0);
        chk1("bk_rd", brd[u], !wr && vl[u]);
        chk32("adio_in", adio[u], (!wr && rx && sd[u]) ? xr : 32'h0);
        chk1("bk_wr", bwr[u], pv);
        if (pv) begin
          chk32("bk_wdata", bwd[u], pd);
          chk32("wr_addr", baddr[u], pa);
        end
        if (!wr && rx) chk32("rd_addr", baddr[u], st + 32'(4 * done));
        pv = vl[u] && wr;
        if (vl[u]) begin
          pd = wdat[u];
          pa = st + 32'(4 * done);
          done++;
        end
        if (e >= 0 && k == e + 1) begin
          fin = 1'b1;
          break;
        end
      end
      if (!fin) begin
        checks++; fails++;
        $display("FAIL txn_timeout: transaction on unit %0d did not complete", u);
      end
    end
  endtask

  typedef struct {
    int u;
    logic [7:0] hit;
    logic wr;
    logic [15:0] c;
    logic [31:0] a;
    int n;
    logic [1:0] xsel;
    logic xab;
    int lat;
  } vec_t;
  vec_t tv [8];

  initial begin
    int u, lat;
    logic [7:0] h;
    logic w, xab;
    logic [15:0] c;
    logic [1:0] xs;
    int r;
    tv[0] = '{0, 8'h01, 1'b1, 16'h0080, 32'h10000114, 3, 2'b01, 1'b0, 1};
    tv[1] = '{0, 8'h02, 1'b0, 16'h0040, 32'h20000000, 4, 2'b10, 1'b0, 1};
    tv[2] = '{0, 8'h01, 1'b1, 16'h0004, 32'h00000000, 0, 2'b01, 1'b1, 0};
    tv[3] = '{1, 8'h01, 1'b1, 16'h0080, 32'h00000100, 6, 2'b01, 1'b0, 4};
    tv[4] = '{1, 8'h03, 1'b0, 16'h0040, 32'h00000202, 2, 2'b01, 1'b0, 4};
    tv[5] = '{0, 8'h01, 1'b0, 16'h0040, 32'hFFFFFFFC, 2, 2'b01, 1'b0, 1};
    tv[6] = '{0, 8'h02, 1'b1, 16'h0040, 32'h00000000, 0, 2'b10, 1'b1, 0};
    tv[7] = '{0, 8'h04, 1'b0, 16'h0040, 32'h00000000, 0, 2'b00, 1'b0, 0};
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bh[i] = '0; wrdn[i] = 1'b0; cmd[i] = '0; ad[i] = '0; sd[i] = 1'b0; vl[i] = 1'b0;
      wdat[i] = '0; rdat[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1("reset_ready", rdy[i], 1'b0);
      chk1("reset_term", trm[i], 1'b0);
      chk1("reset_abort", abt[i], 1'b0);
      chk32("reset_sel", 32'(sel[i]), 32'h0);
      chk32("reset_addr", baddr[i], 32'h0);
      chk1("reset_wr", bwr[i], 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      run_txn(tv[i].u, tv[i].hit, tv[i].wr, tv[i].c, tv[i].a, tv[i].n, tv[i].xsel, tv[i].xab, tv[i].lat);
    // reset asserted between edges while a write strobe is pending
    @(posedge clk); #1;
    bh[0] = 8'h01; wrdn[0] = 1'b1; cmd[0] = 16'h0080; ad[0] = 32'h00000440; sd[0] = 1'b0; vl[0] = 1'b0;
    @(posedge clk); #1;
    bh[0] = 8'h00; sd[0] = 1'b1; vl[0] = 1'b1; wdat[0] = 32'h11112222;
    @(posedge clk); #1;
    wdat[0] = 32'h33334444;
    @(negedge clk);
    chk1("rst_pre_wr", bwr[0], 1'b1);
    chk32("rst_pre_addr", baddr[0], 32'h00000440);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_async_ready", rdy[0], 1'b0);
    chk1("rst_async_wr", bwr[0], 1'b0);
    chk32("rst_async_addr", baddr[0], 32'h0);
    chk32("rst_async_wdata", bwd[0], 32'h0);
    chk32("rst_async_sel", 32'(sel[0]), 32'h0);
    chk32("rst_async_adio", adio[0], 32'h0);
    @(posedge clk); #1;
    sd[0] = 1'b0; vl[0] = 1'b0;
    @(negedge clk);
    chk1("rst_hold_wr", bwr[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("rst_after_wr", bwr[0], 1'b0);
    chk1("rst_after_ready", rdy[0], 1'b0);
    for (int i = 0; i < 40; i++) begin
      u = int'($urandom_range(0, 1));
      h = 8'($urandom);
      if (h[1:0] == 2'b00 && $urandom_range(0, 3) != 0) h[0] = 1'b1;
      w = 1'($urandom);
      r = int'($urandom_range(0, 5));
      c = r < 4 ? (w ? 16'h0080 : 16'h0040) : r == 4 ? (w ? 16'h0040 : 16'h0080) : 16'h1 << $urandom_range(0, 15);
      xab = !((c == 16'h0080 && w) || (c == 16'h0040 && !w));
      xs = h[0] ? 2'b01 : h[1] ? 2'b10 : 2'b00;
      lat = u != 0 ? 4 : 1;
      run_txn(u, h, w, c, $urandom, 1 + int'($urandom_range(0, 19)), xs, xab, lat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
